// File: rtl/corefifo_gray_bin_pipe_if.sv
// rtl/corefifo_gray_bin_pipe_if.sv - handshake bundle for the Gray/binary pointer converter
// Input beat (valid/ready/dir/data) and output beat (valid/ready/data/dir) of one converter.
interface corefifo_gray_bin_pipe_if #(
  parameter int ADDRWIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 dir_sel;
  logic [ADDRWIDTH:0]   data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDRWIDTH:0]   data_out;
  logic                 out_dir;

  modport master (
    output in_valid, dir_sel, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_dir
  );

  modport slave (
    input  in_valid, dir_sel, data_in, out_ready,
    output in_ready, out_valid, data_out, out_dir
  );
endinterface

// File: rtl/corefifo_gray_bin_pipe.sv
// rtl/corefifo_gray_bin_pipe.sv - pipelined handshaked Gray<->binary pointer converter
// Converts in stage 0, later stages only delay; optional Gray single-step checker on accept.
module corefifo_gray_bin_pipe #(
  parameter int ADDRWIDTH   = 3,
  parameter int PIPE_STAGES = 2,
  parameter int STEP_CHECK  = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sync_clr,
  corefifo_gray_bin_pipe_if.slave    bus,
  output logic                       step_err,
  output logic [7:0]                 step_cnt
);

  localparam int W    = ADDRWIDTH + 1;
  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] dir;
  logic [W-1:0]           data [PIPE_STAGES];
  logic                   adv;
  logic [W-1:0]           conv;

  // Whole pipe moves as one shift register; it only stalls when the output beat is stuck.
  assign adv          = !vld[LAST] || bus.out_ready;
  assign bus.in_ready = adv;
  assign conv         = bus.dir_sel ? bin2gray(bus.data_in) : gray2bin(bus.data_in);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      dir <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data[k] <= '0;
      end
    end else if (adv) begin
      vld[0]  <= bus.in_valid;
      dir[0]  <= bus.dir_sel;
      data[0] <= conv;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        vld[k]  <= vld[k-1];
        dir[k]  <= dir[k-1];
        data[k] <= data[k-1];
      end
    end
  end

  assign bus.out_valid = vld[LAST];
  assign bus.out_dir   = dir[LAST];
  assign bus.data_out  = data[LAST];

  generate
    if (STEP_CHECK != 0) begin : g_step
      logic [W-1:0] g_prev;
      logic [W-1:0] g_cur;
      logic         hist_vld;
      logic         accept;
      logic         bad_step;
      logic         err_q;
      logic [7:0]   cnt_q;

      // Both directions are judged in the Gray domain, where a healthy pointer moves one bit.
      assign g_cur    = bus.dir_sel ? bin2gray(bus.data_in) : bus.data_in;
      assign accept   = bus.in_valid && adv;
      assign bad_step = hist_vld && ($countones(g_cur ^ g_prev) != 1);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          g_prev   <= '0;
          hist_vld <= 1'b0;
          err_q    <= 1'b0;
          cnt_q    <= '0;
        end else if (sync_clr) begin
          err_q    <= 1'b0;
          cnt_q    <= '0;
          hist_vld <= accept;
          if (accept) begin
            g_prev <= g_cur;
          end
        end else if (accept) begin
          g_prev   <= g_cur;
          hist_vld <= 1'b1;
          if (bad_step) begin
            err_q <= 1'b1;
            if (cnt_q != 8'hFF) begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
      end

      assign step_err = err_q;
      assign step_cnt = cnt_q;
    end else begin : g_nostep
      assign step_err = 1'b0;
      assign step_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_corefifo_gray_bin_pipe.sv
// tb/tb_corefifo_gray_bin_pipe.sv - directed bench for the Gray/binary pointer converter
// Three instances (1, 2, 4 stages) share one stimulus; checks run against a hand-written Gray table.
module tb_corefifo_gray_bin_pipe;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sync_clr;
  logic       in_valid;
  logic       dir_sel;
  logic       out_ready;
  logic [3:0] data_in;

  int total = 0;
  int bad   = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  logic       vdir [32];
  logic [3:0] vval [32];
  logic [3:0] vexp [32];

  logic       step_err1, step_err2, step_err4;
  logic [7:0] step_cnt1, step_cnt2, step_cnt4;

  always #5 clk = ~clk;

  corefifo_gray_bin_pipe_if #(.ADDRWIDTH(3)) i1 ();
  corefifo_gray_bin_pipe_if #(.ADDRWIDTH(3)) i2 ();
  corefifo_gray_bin_pipe_if #(.ADDRWIDTH(3)) i4 ();

  assign i1.in_valid  = in_valid;
  assign i1.dir_sel   = dir_sel;
  assign i1.data_in   = data_in;
  assign i1.out_ready = out_ready;
  assign i2.in_valid  = in_valid;
  assign i2.dir_sel   = dir_sel;
  assign i2.data_in   = data_in;
  assign i2.out_ready = out_ready;
  assign i4.in_valid  = in_valid;
  assign i4.dir_sel   = dir_sel;
  assign i4.data_in   = data_in;
  assign i4.out_ready = out_ready;

  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .PIPE_STAGES(1), .STEP_CHECK(1)) u_p1 (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .bus(i1.slave),
    .step_err(step_err1), .step_cnt(step_cnt1)
  );
  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .PIPE_STAGES(2), .STEP_CHECK(1)) u_p2 (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .bus(i2.slave),
    .step_err(step_err2), .step_cnt(step_cnt2)
  );
  corefifo_gray_bin_pipe #(.ADDRWIDTH(3), .PIPE_STAGES(4), .STEP_CHECK(1)) u_p4 (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .bus(i4.slave),
    .step_err(step_err4), .step_cnt(step_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic accept_one(input logic d, input logic [3:0] v);
    dir_sel  = d;
    data_in  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_step(input string tag, input logic e, input logic [7:0] c);
    @(negedge clk);
    check({tag, "_err"}, step_err2, e);
    check({tag, "_cnt"}, step_cnt2, c);
    tick();
  endtask

  // Back-to-back stream into the 2-stage instance; each beat must appear exactly 2 cycles later.
  task automatic run_vec(input string tag, input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        dir_sel  = vdir[i];
        data_in  = vval[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        check({tag, "_vld"},  i2.out_valid, 1);
        check({tag, "_data"}, i2.data_out,  vexp[i-2]);
        check({tag, "_dir"},  i2.out_dir,   vdir[i-2]);
      end else begin
        check({tag, "_lat"},  i2.out_valid, 0);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [4:0] got4 [$];
    logic [4:0] q1 [$];
    logic [4:0] q4 [$];
    logic [3:0] held;
    logic       stalled;
    int         sent;
    int         seen;
    int         lat1, lat2, lat4;

    rstn      = 1'b0;
    sync_clr  = 1'b0;
    in_valid  = 1'b0;
    dir_sel   = 1'b0;
    data_in   = 4'd0;
    out_ready = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    check("rst_ovld", i2.out_valid, 0);
    check("rst_data", i2.data_out,  0);
    check("rst_dir",  i2.out_dir,   0);
    check("rst_err",  step_err2,    0);
    check("rst_cnt",  step_cnt2,    0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_inrdy", i2.in_ready, 1);
    tick();

    // Gray count 0000..1000 decodes to 0..15
    for (int i = 0; i < 16; i++) begin
      vdir[i] = 1'b0;
      vval[i] = gray_tab[i];
      vexp[i] = 4'(i);
    end
    run_vec("t1", 16);
    check("t1_err", step_err2, 0);

    // Mixed directions back-to-back; these are also bad Gray steps (dist 4, 4, 0)
    vdir[0] = 1'b1; vval[0] = 4'd5;     vexp[0] = 4'b0111;
    vdir[1] = 1'b1; vval[1] = 4'd15;    vexp[1] = 4'b1000;
    vdir[2] = 1'b0; vval[2] = 4'b1000;  vexp[2] = 4'd15;
    run_vec("t2", 3);
    check("t2_err", step_err2, 1);
    check("t2_cnt", step_cnt2, 3);

    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check_step("t2_clr", 1'b0, 8'd0);

    // Step checker boundaries
    accept_one(1'b0, 4'b0011);
    accept_one(1'b0, 4'b0000);
    check_step("t3_d2", 1'b1, 8'd1);
    accept_one(1'b0, 4'b0000);
    check_step("t3_d0", 1'b1, 8'd2);
    sync_clr = 1'b1;
    accept_one(1'b0, 4'b0001);
    sync_clr = 1'b0;
    check_step("t3_clr", 1'b0, 8'd0);
    accept_one(1'b0, 4'b0010);
    check_step("t3_hist", 1'b1, 8'd1);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    accept_one(1'b0, 4'b1000);
    accept_one(1'b0, 4'b0000);
    check_step("t3_wrap", 1'b0, 8'd0);

    // Back-pressure: out_ready low for cycles 3..7 of an 8-beat stream
    drain(4);
    sent    = 0;
    stalled = 1'b0;
    held    = 4'd0;
    for (int c = 0; c < 60; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (sent < 8) begin
        dir_sel  = 1'b1;
        data_in  = 4'(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 3) check("t4_inrdy", i2.in_ready, 0);
      if (stalled) check("t4_hold", i2.data_out, held);
      if (i2.out_valid && out_ready) got4.push_back({i2.out_dir, i2.data_out});
      stalled = i2.out_valid && !out_ready;
      held    = i2.data_out;
      if (in_valid && i2.in_ready) sent++;
      tick();
      if (got4.size() == 8) break;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("t4_count", got4.size(), 8);
    for (int k = 0; k < got4.size() && k < 8; k++) begin
      check("t4_beat", got4[k], {1'b1, gray_tab[k]});
    end

    // Reset with two beats in flight
    drain(6);
    dir_sel  = 1'b0;
    data_in  = 4'b0001;
    in_valid = 1'b1;
    tick();
    data_in  = 4'b0011;
    tick();
    in_valid = 1'b0;
    check("t5_pre", i2.out_valid, 1);
    rstn = 1'b0;
    #1;
    check("t5_rst2", i2.out_valid, 0);
    check("t5_rst1", i1.out_valid, 0);
    tick();
    tick();
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (i1.out_valid || i2.out_valid || i4.out_valid) seen++;
    end
    tick();
    check("t5_stale", seen, 0);

    // Latency per pipeline depth
    dir_sel  = 1'b0;
    data_in  = gray_tab[6];
    in_valid = 1'b1;
    lat1 = 0;
    lat2 = 0;
    lat4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (lat1 == 0 && i1.out_valid) lat1 = n;
      if (lat2 == 0 && i2.out_valid) lat2 = n;
      if (lat4 == 0 && i4.out_valid) lat4 = n;
    end
    tick();
    check("t6_lat1", lat1, 1);
    check("t6_lat2", lat2, 2);
    check("t6_lat4", lat4, 4);

    // Exhaustive both directions through the 1- and 4-stage instances
    for (int c = 0; c < 38; c++) begin
      if (c < 16) begin
        dir_sel  = 1'b0;
        data_in  = gray_tab[c];
        in_valid = 1'b1;
      end else if (c < 32) begin
        dir_sel  = 1'b1;
        data_in  = 4'(c - 16);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i1.out_valid) q1.push_back({i1.out_dir, i1.data_out});
      if (i4.out_valid) q4.push_back({i4.out_dir, i4.data_out});
      tick();
    end
    check("t6_n1", q1.size(), 32);
    check("t6_n4", q4.size(), 32);
    for (int k = 0; k < 32; k++) begin
      logic [4:0] exp_b;
      exp_b = (k < 16) ? {1'b0, 4'(k)} : {1'b1, gray_tab[k-16]};
      if (k < q1.size()) check("t6_p1", q1[k], exp_b);
      if (k < q4.size()) check("t6_p4", q4[k], exp_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
